// File: rtl/mips_run_pkg.sv
// Shared types and constants for the MIPS run monitor: FSM states, done-cause codes
// and the default halt instruction word.
package mips_run_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_HALT  = 2'd1,
        CAUSE_STALL = 2'd2,
        CAUSE_LIMIT = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // beq $0,$0,-1 : the core spins on itself
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h1000FFFF;

endpackage

// File: rtl/mips_run_monitor_trace_ring.sv
// Circular trace buffer: keeps the most recent DEPTH entries, overwriting the oldest
// when full, with a registered one-cycle pop port.
module trace_ring #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic                     rd_valid_o,
    output logic [W-1:0]             rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          rd_valid_q, rd_valid_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          full, do_pop, overwrite;

    always_comb begin
        full       = (count_q == CW'(DEPTH));
        do_pop     = pop_i && (count_q != '0);
        overwrite  = push_i && full && !do_pop;
        wr_d       = push_i ? wr_q + AW'(1) : wr_q;
        // An overwrite discards the oldest entry, so the read pointer follows the writer
        rd_d       = (do_pop || overwrite) ? rd_q + AW'(1) : rd_q;
        count_d    = count_q;
        if (push_i && !do_pop && !full) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !push_i) begin
            count_d = count_q - CW'(1);
        end
        ovf_d      = ovf_q | overwrite;
        rd_valid_d = do_pop;
        rd_data_d  = do_pop ? mem_q[rd_q] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign count_o    = count_q;
    assign ovf_o      = ovf_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Run-control and trace monitor for the MIPS_R2000 core: counts RUN cycles, traces
// PC changes and ends the run on halt instruction, PC stall or cycle limit.
module mips_run_monitor
    import mips_run_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned STALL_LIMIT = 8,
    parameter logic [31:0] HALT_INSTR  = HALT_INSTR_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           EN,
    input  logic [31:0]                    PC,
    input  logic [31:0]                    INSTR,
    input  logic [CNT_W-1:0]               CYCLE_LIMIT,
    input  logic                           RD_EN,
    output logic                           RD_VALID,
    output logic [31:0]                    RD_PC,
    output logic [31:0]                    RD_INSTR,
    output logic [$clog2(TRACE_DEPTH):0]   TRACE_COUNT,
    output logic                           TRACE_OVF,
    output logic [CNT_W-1:0]               CYCLES,
    output logic                           RUNNING,
    output logic                           DONE,
    output logic [1:0]                     DONE_CAUSE
);

    localparam int unsigned    SW        = $clog2(STALL_LIMIT);
    localparam logic [SW-1:0]  STALL_MAX = SW'(STALL_LIMIT - 1);

    state_e           state_q, state_d;
    cause_e           cause_q, cause_d;
    logic [CNT_W-1:0] cycles_q, cycles_d, cycles_inc;
    logic [SW-1:0]    stall_q, stall_d;
    logic [31:0]      last_pc_q, last_pc_d;
    logic             first_q, first_d;
    logic             pc_changed, push;
    logic [63:0]      rd_data;

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        cycles_d   = cycles_q;
        stall_d    = stall_q;
        last_pc_d  = last_pc_q;
        first_d    = first_q;
        push       = 1'b0;
        pc_changed = first_q || (PC != last_pc_q);
        cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                cycles_d = '0;
                stall_d  = '0;
                first_d  = 1'b1;
                if (EN) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cycles_d  = cycles_inc;
                first_d   = 1'b0;
                last_pc_d = PC;
                if (pc_changed) begin
                    push    = 1'b1;
                    stall_d = '0;
                end else if (stall_q != STALL_MAX) begin
                    stall_d = stall_q + SW'(1);
                end
                // Halt outranks stall, stall outranks limit; the sample itself is still traced
                if (INSTR == HALT_INSTR) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (!pc_changed && (stall_d == STALL_MAX)) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_STALL;
                end else if ((CYCLE_LIMIT != '0) && (cycles_inc == CYCLE_LIMIT)) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_LIMIT;
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            cycles_q  <= '0;
            stall_q   <= '0;
            last_pc_q <= '0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            cycles_q  <= cycles_d;
            stall_q   <= stall_d;
            last_pc_q <= last_pc_d;
            first_q   <= first_d;
        end
    end

    trace_ring #(
        .DEPTH (TRACE_DEPTH),
        .W     (64)
    ) u_trace_ring (
        .clk         (CLK),
        .rst_n       (RST),
        .push_i      (push),
        .push_data_i ({PC, INSTR}),
        .pop_i       (RD_EN),
        .rd_valid_o  (RD_VALID),
        .rd_data_o   (rd_data),
        .count_o     (TRACE_COUNT),
        .ovf_o       (TRACE_OVF)
    );

    assign RD_PC      = rd_data[63:32];
    assign RD_INSTR   = rd_data[31:0];
    assign CYCLES     = cycles_q;
    assign RUNNING    = (state_q == ST_RUN);
    assign DONE       = (state_q == ST_DONE);
    assign DONE_CAUSE = cause_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Self-checking bench for mips_run_monitor: a queue-based run model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mips_run_monitor;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned SL    = 8;
    localparam int unsigned CW    = 32;
    localparam logic [31:0] HALT  = 32'h1000FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [CW-1:0] cyc_lim = '0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_pc, rd_instr;
    logic [4:0]  trace_count;
    logic        trace_ovf;
    logic [CW-1:0] cycles;
    logic        running, done;
    logic [1:0]  done_cause;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mips_run_monitor #(
        .TRACE_DEPTH (DEPTH),
        .STALL_LIMIT (SL),
        .HALT_INSTR  (HALT),
        .CNT_W       (CW)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .EN          (en),
        .PC          (pc),
        .INSTR       (instr),
        .CYCLE_LIMIT (cyc_lim),
        .RD_EN       (rd_en),
        .RD_VALID    (rd_valid),
        .RD_PC       (rd_pc),
        .RD_INSTR    (rd_instr),
        .TRACE_COUNT (trace_count),
        .TRACE_OVF   (trace_ovf),
        .CYCLES      (cycles),
        .RUNNING     (running),
        .DONE        (done),
        .DONE_CAUSE  (done_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run model: state 0 idle, 1 run, 2 done; m_same counts identical consecutive samples
    int              m_state = 0;
    longint unsigned m_cycles = 0;
    logic [31:0]     m_last = '0;
    bit              m_first = 1'b1;
    int              m_same = 0;
    logic [63:0]     m_q[$];
    bit              m_ovf = 1'b0;
    bit              m_rdv = 1'b0;
    logic [63:0]     m_rd = '0;
    logic [1:0]      m_cause = 2'd0;
    bit              m_changed;

    always @(posedge clk) begin
        if (!rst) begin
            m_state = 0; m_cycles = 0; m_last = '0; m_first = 1'b1; m_same = 0;
            m_q.delete(); m_ovf = 1'b0; m_rdv = 1'b0; m_rd = '0; m_cause = 2'd0;
        end else begin
            if (rd_en && m_q.size() > 0) begin
                m_rdv = 1'b1;
                m_rd  = m_q.pop_front();
            end else begin
                m_rdv = 1'b0;
            end
            if (m_state == 0) begin
                if (en) m_state = 1;
            end else if (m_state == 1) begin
                if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
                m_changed = m_first || (pc != m_last);
                m_first = 1'b0;
                m_last  = pc;
                if (m_changed) begin
                    m_same = 1;
                    m_q.push_back({pc, instr});
                    if (m_q.size() > DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1'b1;
                    end
                end else begin
                    m_same++;
                end
                if (instr == HALT) begin
                    m_state = 2; m_cause = 2'd1;
                end else if (m_same >= SL) begin
                    m_state = 2; m_cause = 2'd2;
                end else if (cyc_lim != 0 && m_cycles == longint'(cyc_lim)) begin
                    m_state = 2; m_cause = 2'd3;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_running", running, m_state == 1);
            check("m_done", done, m_state == 2);
            check("m_cause", done_cause, m_cause);
            check("m_cycles", cycles, m_cycles);
            check("m_count", trace_count, m_q.size());
            check("m_ovf", trace_ovf, m_ovf);
            check("m_rd_valid", rd_valid, m_rdv);
            check("m_rd_pc", rd_pc, m_rd[63:32]);
            check("m_rd_instr", rd_instr, m_rd[31:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic start();
        en = 1'b1;
        step();
        en = 1'b0;
    endtask

    task automatic sample(input logic [31:0] pc_v, input logic [31:0] instr_v);
        pc    = pc_v;
        instr = instr_v;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        step();
        chk_en = 1'b1;
        rst = 1'b1;
        check("reset_idle", {running, done, done_cause}, 4'd0);

        // Reset mid-run, with a pop so the read register holds non-zero data first
        start();
        for (int i = 0; i < 5; i++) begin
            rd_en = (i == 4);
            sample(32'h100 + 32'(4 * i), 32'(i + 1));
        end
        rd_en = 1'b0;
        check("mid_cycles", cycles, 5);
        check("mid_count", trace_count, 4);
        check("mid_rd_pc", rd_pc, 32'h100);
        rst = 1'b0;
        step();
        check("rst_all", {rd_valid, rd_pc, rd_instr, trace_count, trace_ovf, cycles,
                          running, done, done_cause}, '0);
        rst = 1'b1;
        start();
        sample(32'h200, 32'h0);
        check("restart_cycles", cycles, 1);

        // Empty pop in IDLE
        do_reset();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("empty_rd_valid", rd_valid, 0);
        check("empty_count", trace_count, 0);

        // Halt
        do_reset();
        start();
        sample(32'h00, 32'h1);
        sample(32'h04, 32'h2);
        sample(32'h08, HALT);
        check("halt_done", done, 1);
        check("halt_cause", done_cause, 1);
        check("halt_cycles", cycles, 3);
        check("halt_count", trace_count, 3);
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            step();
            check("halt_pop_valid", rd_valid, 1);
            check("halt_pop_pc", rd_pc, 32'(4 * i));
        end
        rd_en = 1'b0;

        // Stall
        do_reset();
        start();
        sample(32'h10, 32'h11);
        n = 0;
        while (!done && n < 20) begin
            sample(32'h14, 32'h22);
            n++;
        end
        check("stall_samples", n, 8);
        check("stall_cause", done_cause, 2);
        check("stall_cycles", cycles, 9);
        check("stall_count", trace_count, 2);

        // Full FIFO, push and pop on the same cycle
        do_reset();
        cyc_lim = 20;
        start();
        for (int i = 0; i < 16; i++) sample(32'(4 * i), 32'(i));
        check("full_count", trace_count, 16);
        check("full_ovf", trace_ovf, 0);
        rd_en = 1'b1;
        sample(32'd64, 32'd16);
        rd_en = 1'b0;
        check("pp_valid", rd_valid, 1);
        check("pp_pc", rd_pc, 32'h0);
        check("pp_count", trace_count, 16);
        check("pp_ovf", trace_ovf, 0);
        n = 17;
        while (!done && n < 40) begin
            sample(32'(4 * n), 32'(n));
            n++;
        end
        check("lim20_cause", done_cause, 3);
        check("lim20_cycles", cycles, 20);
        check("lim20_ovf", trace_ovf, 1);

        // Cycle limit 2048
        do_reset();
        cyc_lim = 2048;
        start();
        n = 0;
        while (!done && n < 2100) begin
            sample(32'(4 * n), 32'h0);
            n++;
        end
        check("lim_cause", done_cause, 3);
        check("lim_cycles", cycles, 2048);
        check("lim_ovf", trace_ovf, 1);
        check("lim_count", trace_count, 16);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("lim_pop_pc", rd_pc, 32'h1FC0);

        // Halt and limit on the same sample: halt wins
        do_reset();
        cyc_lim = 3;
        start();
        sample(32'h0, 32'h0);
        sample(32'h4, 32'h0);
        sample(32'h8, HALT);
        check("tie_cause", done_cause, 1);
        check("tie_cycles", cycles, 3);
        check("tie_done", done, 1);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
